// File: rtl/tof_avg_filter_if.sv
// rtl/tof_avg_filter_if.sv - sample/average bus between the TOF counter, the filter and the estimator
interface tof_avg_filter_if;
    logic signed [7:0] tof_count;
    logic              tof_ready;
    logic              clear;
    logic signed [7:0] avg_out;
    logic              avg_valid;
    logic              window_full;
    logic              stale;

    modport master (
        output tof_count, tof_ready, clear,
        input  avg_out, avg_valid, window_full, stale
    );

    modport slave (
        input  tof_count, tof_ready, clear,
        output avg_out, avg_valid, window_full, stale
    );
endinterface

// File: rtl/tof_avg_filter.sv
// rtl/tof_avg_filter.sv - moving average over the last 2^LOG2_N TOF samples; TOF_TIMEOUT_EN adds a stale timeout
module tof_avg_filter #(
    parameter int LOG2_N  = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset_L,
    tof_avg_filter_if.slave  io_bus
);

    localparam int N  = 1 << LOG2_N;
    localparam int SW = 8 + LOG2_N;
    localparam logic [LOG2_N:0] FILL_LAST = (LOG2_N + 1)'(N - 1);
    localparam logic [LOG2_N:0] FILL_MAX  = (LOG2_N + 1)'(N);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic signed [7:0]     r_buf [N];
    logic [LOG2_N-1:0]     r_wr_ptr;
    logic [LOG2_N:0]       r_fill;
    logic signed [SW-1:0]  r_sum;
    logic signed [7:0]     r_avg_out;
    logic                  r_avg_valid;
    logic                  r_pend;

    logic                  w_accept;
    logic                  w_flush;
    logic                  w_timeout;
    logic signed [SW-1:0]  w_sum_nxt;
    logic signed [SW-1:0]  w_avg_full;

    assign w_accept   = io_bus.tof_ready && !io_bus.clear;
    assign w_flush    = io_bus.clear || w_timeout;
    // Entries are zero while filling, so the subtraction is exact from the first sample.
    assign w_sum_nxt  = r_sum + SW'(io_bus.tof_count) - SW'(r_buf[r_wr_ptr]);
    assign w_avg_full = r_sum >>> LOG2_N;

`ifdef TOF_TIMEOUT_EN
    localparam logic [15:0] IDLE_MAX = 16'(TIMEOUT);

    logic [15:0] r_idle;
    logic        r_stale;

    assign w_timeout = !w_accept && !io_bus.clear && (r_idle == IDLE_MAX - 16'd1);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_idle  <= '0;
            r_stale <= 1'b0;
        end else begin
            if (w_accept || io_bus.clear)
                r_idle <= '0;
            else if (r_idle != IDLE_MAX)
                r_idle <= r_idle + 16'd1;

            if (w_accept)
                r_stale <= 1'b0;
            else if (w_timeout)
                r_stale <= 1'b1;
        end
    end

    assign io_bus.stale = r_stale;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign io_bus.stale     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            r_state <= ST_FILL;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_flush)
                    w_state_nxt = ST_FILL;
                else if (w_accept && r_fill == FILL_LAST)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_flush)
                    w_state_nxt = ST_FILL;
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < N; i++)
                r_buf[i] <= '0;
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_sum       <= '0;
            r_avg_out   <= '0;
            r_avg_valid <= 1'b0;
            r_pend      <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
            r_pend      <= 1'b0;

            // r_pend marks an accept that left the window full; publish its average one edge later.
            if (r_pend && !w_flush) begin
                r_avg_out   <= w_avg_full[7:0];
                r_avg_valid <= 1'b1;
            end

            if (w_flush) begin
                for (int i = 0; i < N; i++)
                    r_buf[i] <= '0;
                r_wr_ptr <= '0;
                r_fill   <= '0;
                r_sum    <= '0;
            end else if (w_accept) begin
                r_buf[r_wr_ptr] <= io_bus.tof_count;
                r_wr_ptr        <= r_wr_ptr + LOG2_N'(1);
                r_sum           <= w_sum_nxt;
                if (r_fill != FILL_MAX)
                    r_fill <= r_fill + (LOG2_N + 1)'(1);
                r_pend <= (w_state_nxt == ST_RUN);
            end
        end
    end

    assign io_bus.avg_out     = r_avg_out;
    assign io_bus.avg_valid   = r_avg_valid;
    assign io_bus.window_full = (r_state == ST_RUN);

endmodule

// File: tb/tb_tof_avg_filter.sv
// tb/tb_tof_avg_filter.sv - directed and randomized checks of tof_avg_filter against a sample-window model
module tb_tof_avg_filter;

    localparam int LOG2_N  = 3;
    localparam int N       = 1 << LOG2_N;
    localparam int TIMEOUT = 16;

    logic clk;
    logic reset_L;

    tof_avg_filter_if bus ();

    tof_avg_filter #(
        .LOG2_N  (LOG2_N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int win[$];
    bit pend;
    bit exp_valid;
    int exp_avg;
    bit exp_stale;
    int idle;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int win_sum();
        int s = 0;
        foreach (win[i]) s += win[i];
        return s;
    endfunction

    function automatic int floor_div(input int s);
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    task automatic model_reset();
        win.delete();
        pend      = 1'b0;
        exp_valid = 1'b0;
        exp_avg   = 0;
        exp_stale = 1'b0;
        idle      = 0;
    endtask

    task automatic check_outputs();
        check("avg_valid", int'(bus.avg_valid), int'(exp_valid));
        check("avg_out", int'(bus.avg_out), exp_avg);
        check("window_full", int'(bus.window_full), int'(win.size() == N));
        check("stale", int'(bus.stale), int'(exp_stale));
    endtask

    task automatic step(input bit rdy, input int d, input bit clr);
        @(negedge clk);
        bus.tof_ready = rdy;
        bus.tof_count = 8'(d);
        bus.clear     = clr;
        @(posedge clk);
        #1;
        exp_valid = pend && !clr;
        if (exp_valid) exp_avg = floor_div(win_sum());
        pend = 1'b0;
        if (clr) begin
            win.delete();
            idle = 0;
        end else if (rdy) begin
            win.push_back(d);
            if (win.size() > N) void'(win.pop_front());
            pend      = (win.size() == N);
            idle      = 0;
            exp_stale = 1'b0;
        end else begin
`ifdef TOF_TIMEOUT_EN
            if (idle < TIMEOUT) begin
                idle++;
                if (idle == TIMEOUT) begin
                    win.delete();
                    exp_stale = 1'b1;
                end
            end
`endif
        end
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.tof_ready = 1'b0;
        bus.clear     = 1'b0;
        #2 reset_L = 1'b0;
        #1;
        model_reset();
        check("rst_avg_out", int'(bus.avg_out), 0);
        check("rst_avg_valid", int'(bus.avg_valid), 0);
        check("rst_window_full", int'(bus.window_full), 0);
        check("rst_stale", int'(bus.stale), 0);
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int cnt;
        int d;
        reset_L       = 1'b0;
        bus.tof_ready = 1'b0;
        bus.tof_count = '0;
        bus.clear     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("init_avg_out", int'(bus.avg_out), 0);
        check("init_window_full", int'(bus.window_full), 0);
        @(negedge clk);
        reset_L = 1'b1;

        // Reset mid-stream after 5 samples.
        for (int i = 0; i < 5; i++) step(1'b1, 20 + i, 1'b0);
        do_reset();

        for (int i = 0; i < N; i++) step(1'b1, 10, 1'b0);
        step(1'b0, 0, 1'b0);
        check("avg10_out", int'(bus.avg_out), 10);
        check("avg10_valid", int'(bus.avg_valid), 1);
        check("avg10_full", int'(bus.window_full), 1);

        step(1'b1, 18, 1'b0);
        step(1'b0, 0, 1'b0);
        check("avg11_out", int'(bus.avg_out), 11);

        cnt = 0;
        for (int i = 0; i < N + 1; i++) begin
            step(i < N, int'($urandom_range(255)) - 128, 1'b0);
            if (bus.avg_valid) cnt++;
        end
        check("b2b_pulses", cnt, N);

        step(1'b0, 0, 1'b1);
        for (int i = 0; i < N; i++) step(1'b1, -3, 1'b0);
        step(1'b0, 0, 1'b0);
        check("neg3_out", int'(bus.avg_out), -3);
        step(1'b1, -4, 1'b0);
        step(1'b0, 0, 1'b0);
        check("floor_out", int'(bus.avg_out), -4);

        step(1'b0, 0, 1'b1);
        for (int i = 0; i < N; i++) step(1'b1, 127, 1'b0);
        step(1'b0, 0, 1'b0);
        check("max_out", int'(bus.avg_out), 127);
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < N; i++) step(1'b1, -128, 1'b0);
        step(1'b0, 0, 1'b0);
        check("min_out", int'(bus.avg_out), -128);

        // Clear colliding with a strobe while in RUN, right after the last fill sample.
        for (int i = 0; i < N; i++) step(1'b1, 10, 1'b0);
        step(1'b1, 50, 1'b1);
        check("clr_full", int'(bus.window_full), 0);
        check("clr_valid", int'(bus.avg_valid), 0);
        for (int i = 0; i < N; i++) step(1'b1, 5 * i, 1'b0);
        step(1'b0, 0, 1'b0);
        check("clr_refill_valid", int'(bus.avg_valid), 1);

        for (int i = 0; i < TIMEOUT + 4; i++) step(1'b0, 0, 1'b0);
        for (int i = 0; i < N + 2; i++) step(1'b1, int'($urandom_range(255)) - 128, 1'b0);

        for (int c = 0; c < 600; c++) begin
            d = int'($urandom_range(255)) - 128;
            if ($urandom_range(99) < 2) begin
                for (int j = 0; j < TIMEOUT + 2; j++) step(1'b0, 0, 1'b0);
            end else begin
                step($urandom_range(99) < 65, d, $urandom_range(99) < 3);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tof_avg_filter.md
# tof_avg_filter

Moving-average filter for time-of-flight samples, sitting directly downstream of the TOF counter in the estimator path. It consumes each signed 8-bit TOF measurement and its one-cycle `tof_ready` strobe, and keeps the last 2^LOG2_N samples in a circular buffer. Once the window is full, it publishes a registered window average with a one-cycle valid pulse.

## Interface
- `LOG2_N`, default 3: log2 of window length; window N = 2^LOG2_N; legal range 1..5.
- `TIMEOUT`, default 1024: stale timeout in clk cycles; only used with `TOF_TIMEOUT_EN`; legal range 2..65535.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset_L`, in, 1: reset, asynchronous, active-low.
- `tof_count`, in, 8: signed TOF sample; sampled only when `tof_ready`=1.
- `tof_ready`, in, 1: one-cycle sample strobe; may be high on consecutive cycles.
- `clear`, in, 1: synchronous flush of window, sum and pointers.
- `avg_out`, out, 8: signed window average, registered.
- `avg_valid`, out, 1: one-cycle pulse when `avg_out` has just been updated.
- `window_full`, out, 1: high while the state is RUN.
- `stale`, out, 1: timeout flag; tied 0 when `TOF_TIMEOUT_EN` is undefined.

## Operation
- **Storage**
  - `buf[0..N-1]`: signed 8-bit entries.
  - `wr_ptr`: LOG2_N bits.
  - `fill`: LOG2_N+1 bits.
  - `sum`: signed 8+LOG2_N bits. `sum` cannot overflow, so there is no saturation logic.
- **FSM states:** FILL (reset state) and RUN.
  - FILL -> RUN on the edge that accepts the Nth sample (`fill` reaches N).
  - RUN -> FILL on `clear` or on a timeout.
  - No other transitions.
- **Sample accept:** rising edge with `tof_ready`=1 and `clear`=0.
  - `sum <= sum + tof_count - buf[wr_ptr]`.
  - `buf[wr_ptr] <= tof_count`.
  - `wr_ptr <= wr_ptr+1`, wrapping N-1 -> 0.
  - `fill` increments, saturating at N.
- **Fill behaviour:** buffer entries are zero during FILL, so the subtraction is exact while filling.
- **Average:** `avg_out <= sum >>> LOG2_N`, an arithmetic shift that rounds toward minus infinity.
  - `avg_out` loads only on the cycle after an accept that leaves the state in RUN; `avg_valid` pulses on that same cycle.
  - In FILL, `avg_valid` stays 0 and `avg_out` holds its last value.
- **`clear`:**
  - Zeros `buf`, `sum`, `wr_ptr` and `fill`; state goes to FILL.
  - Has priority over a coincident `tof_ready`; that sample is dropped.
  - Suppresses a pending `avg_valid` pulse.
  - `avg_out` holds its value.
- **Reset values:** `avg_out`=0, `avg_valid`=0, `window_full`=0, `stale`=0; all internal state is zero and the state is FILL.
- **Reset mid-operation:** aborts immediately to the reset values; no partial sample is retained.

## Timing
- **Cycle numbering:** `tof_ready`=1 during cycle k means the sample is accepted on the edge ending cycle k, and `sum` is valid in cycle k+1.
- **Output latency:** `avg_out` and `avg_valid` update on the edge ending cycle k+1, so `avg_valid` is high during cycle k+2 (2 cycles after the strobe).
- **`window_full`:** rises during cycle k+1 after the Nth accept.
- **Throughput:** back-to-back `tof_ready` gives one `avg_valid` per cycle, each reflecting the window ending at the corresponding sample.
- **Cross-block timing:** the upstream TOF counter emits `tof_ready` at most once per measurement, so in practice strobes are sparse; the block still supports one strobe per cycle.

## Configuration
- **`TOF_TIMEOUT_EN` defined:**
  - A 16-bit idle counter resets on every accept and on `clear`, and otherwise increments, saturating at `TIMEOUT`.
  - On the edge where it reaches `TIMEOUT`:
    - `stale` <= 1.
    - An implicit clear is performed (window flushed, state FILL).
    - `avg_out` holds.
  - `stale` stays 1 until the next accepted sample, which clears it on the same edge the sample is stored.
  - An explicit `clear` does not clear `stale`.
- **`TOF_TIMEOUT_EN` undefined:** no idle counter is built, `stale` is tied 0, and the `TIMEOUT` parameter is ignored.

## Test plan
- Reset asserted mid-stream, after 5 samples → all outputs 0 immediately; after release, 8 new samples are needed before the first `avg_valid`.
- LOG2_N=3, eight strobes with `tof_count`=10 → no `avg_valid` on the first 7; `avg_valid` 2 cycles after the 8th strobe, with `avg_out`=10 and `window_full`=1.
- Continuing that test, one strobe with 18 → sum 88, `avg_out`=11; eight back-to-back strobes → eight consecutive `avg_valid` pulses.
- Eight samples of -3, then one of -4 → `avg_out`=-3, then -4 (sum -25, floor of -3.125 is -4); also check samples +127 ×8 → 127 and -128 ×8 → -128 with no wrap.
- `clear` and `tof_ready` (value 50) in the same cycle while in RUN → sample dropped, `window_full`=0, no `avg_valid`; the next 7 strobes produce no `avg_valid` and the 8th does.
- `TOF_TIMEOUT_EN`, TIMEOUT=16, in RUN with no strobe → `stale`=1 and `window_full`=0 on the 16th idle edge; the next strobe clears `stale`, and `avg_valid` returns after 8 samples. Without the macro, `stale` stays 0 throughout.
